// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - launches one of four processor programs from button edges
// Holds the launched code for HOLD_CYCLES, then waits for cpu_done or a run timeout.
module program_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fib_act,
  input  logic        sort_act,
  input  logic        save_act,
  input  logic        load_act,
  input  logic        cpu_done,
  output logic [31:0] program_selector,
  output logic        busy,
  output logic        pend_valid,
  output logic        done,
  output logic        timeout
);

  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int HW       = $clog2(HOLD_EFF + 1);
  localparam int TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

  state_t          state;
  logic [3:0]      act_now;
  logic [3:0]      act_prev;
  logic [3:0]      rise;
  logic            new_req;
  logic [2:0]      new_code;
  logic [2:0]      sel_code;
  logic [2:0]      pend_code;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   run_cnt;

  assign act_now = {load_act, save_act, sort_act, fib_act};
  assign rise    = act_now & ~act_prev;
  assign new_req = |rise;

  // Fixed priority: lower-numbered programs win, the rest are discarded.
  always_comb begin
    new_code = 3'd0;
    if (rise[0])      new_code = 3'd1;
    else if (rise[1]) new_code = 3'd2;
    else if (rise[2]) new_code = 3'd3;
    else if (rise[3]) new_code = 3'd4;
  end

  assign program_selector = {29'd0, sel_code};
  assign busy             = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      act_prev   <= 4'hF;
      sel_code   <= 3'd0;
      pend_code  <= 3'd0;
      pend_valid <= 1'b0;
      hold_cnt   <= '0;
      run_cnt    <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      act_prev <= act_now;
      done     <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_valid) begin
            sel_code   <= pend_code;
            hold_cnt   <= '0;
            state      <= LAUNCH;
            pend_valid <= new_req;
            pend_code  <= new_code;
          end else if (new_req) begin
            sel_code <= new_code;
            hold_cnt <= '0;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (hold_cnt == HW'(HOLD_EFF - 1)) begin
            sel_code <= 3'd0;
            run_cnt  <= '0;
            state    <= RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          // Completion wins over a coincident timeout.
          if (cpu_done) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (run_cnt == TW'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (state != IDLE && new_req && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_code  <= new_code;
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - scoreboard bench for program_sequencer
// Stimulus pushes expected launches/pulses; a negedge monitor pops and compares.
module tb_program_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fib_act = 1'b0;
  logic        sort_act = 1'b0;
  logic        save_act = 1'b0;
  logic        load_act = 1'b0;
  logic        cpu_done = 1'b0;
  logic [31:0] program_selector;
  logic        busy;
  logic        pend_valid;
  logic        done;
  logic        timeout;

  program_sequencer #(.HOLD_CYCLES(4), .TIMEOUT(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .fib_act          (fib_act),
    .sort_act         (sort_act),
    .save_act         (save_act),
    .load_act         (load_act),
    .cpu_done         (cpu_done),
    .program_selector (program_selector),
    .busy             (busy),
    .pend_valid       (pend_valid),
    .done             (done),
    .timeout          (timeout)
  );

  always #5 clock = ~clock;

  localparam int K_LAUNCH = 0;
  localparam int K_DONE   = 1;
  localparam int K_TO     = 2;

  typedef struct {
    int kind;
    int code;
    int len;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  run_len = 0;
  int  cur_code = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input int kind, input int code, input int len);
    ev_t e;
    e.kind = kind;
    e.code = code;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input int code, input int len);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind %0d code %0d len %0d, expected nothing", kind, code, len);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.code != code || e.len != len) begin
        errors++;
        $display("FAIL sb_event: got kind %0d code %0d len %0d, expected kind %0d code %0d len %0d",
                 kind, code, len, e.kind, e.code, e.len);
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      run_len = 0;
    end else begin
      if (done && timeout) begin
        checks++;
        errors++;
        $display("FAIL done_and_timeout: got both 1, expected at most one");
      end
      if (program_selector != 0) begin
        if (run_len == 0) cur_code = int'(program_selector);
        else if (int'(program_selector) != cur_code) begin
          checks++;
          errors++;
          $display("FAIL sel_changed: got %0d expected %0d", program_selector, cur_code);
        end
        run_len++;
      end else if (run_len > 0) begin
        pop_cmp(K_LAUNCH, cur_code, run_len);
        run_len = 0;
      end
      if (done)    pop_cmp(K_DONE, 0, 0);
      if (timeout) pop_cmp(K_TO, 0, 0);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic finish_run();
    push(K_DONE, 0, 0);
    cpu_done = 1'b1;
    tick(1);
    cpu_done = 1'b0;
    chk("done_pulse", int'(done), 1);
    chk("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    tick(2);
    chk("rst_sel", int'(program_selector), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pend", int'(pend_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_to", int'(timeout), 0);
    reset = 1'b0;
    tick(2);

    // fib for two cycles, 1-cycle latency, four-cycle hold, done 10 cycles later
    push(K_LAUNCH, 1, 4);
    fib_act = 1'b1;
    tick(1);
    chk("fib_latency_sel", int'(program_selector), 1);
    chk("fib_busy", int'(busy), 1);
    tick(1);
    fib_act = 1'b0;
    tick(10);
    chk("fib_run_sel", int'(program_selector), 0);
    finish_run();
    tick(2);

    // fib and load together: fib only, load discarded
    push(K_LAUNCH, 1, 4);
    fib_act = 1'b1;
    load_act = 1'b1;
    tick(1);
    chk("prio_sel", int'(program_selector), 1);
    chk("prio_pend", int'(pend_valid), 0);
    tick(1);
    fib_act = 1'b0;
    load_act = 1'b0;
    tick(6);
    chk("prio_pend_run", int'(pend_valid), 0);
    finish_run();
    tick(3);
    chk("prio_no_load", int'(busy), 0);

    // sort running; save queued, load dropped; save launches after done
    push(K_LAUNCH, 2, 4);
    sort_act = 1'b1;
    tick(1);
    sort_act = 1'b0;
    tick(6);
    save_act = 1'b1;
    tick(1);
    chk("q_pend_save", int'(pend_valid), 1);
    save_act = 1'b0;
    load_act = 1'b1;
    tick(1);
    chk("q_pend_full", int'(pend_valid), 1);
    load_act = 1'b0;
    tick(2);
    finish_run();
    push(K_LAUNCH, 3, 4);
    tick(1);
    chk("q_launch_sel", int'(program_selector), 3);
    chk("q_pend_clr", int'(pend_valid), 0);
    tick(10);
    finish_run();
    tick(2);

    // timeout after 16 RUN cycles
    push(K_LAUNCH, 3, 4);
    push(K_TO, 0, 0);
    save_act = 1'b1;
    tick(1);
    save_act = 1'b0;
    tick(19);
    chk("to_busy_last", int'(busy), 1);
    chk("to_early", int'(timeout), 0);
    tick(1);
    chk("to_pulse", int'(timeout), 1);
    chk("to_busy", int'(busy), 0);
    chk("to_no_done", int'(done), 0);
    tick(1);
    chk("to_single", int'(timeout), 0);
    tick(2);

    // cpu_done on the final RUN cycle resolves as done
    push(K_LAUNCH, 4, 4);
    load_act = 1'b1;
    tick(1);
    load_act = 1'b0;
    tick(19);
    push(K_DONE, 0, 0);
    cpu_done = 1'b1;
    tick(1);
    cpu_done = 1'b0;
    chk("coin_done", int'(done), 1);
    chk("coin_no_to", int'(timeout), 0);
    tick(3);

    // reset mid-LAUNCH with pending, buttons held across release
    sort_act = 1'b1;
    tick(1);
    save_act = 1'b1;
    tick(1);
    chk("rl_sel", int'(program_selector), 2);
    chk("rl_pend", int'(pend_valid), 1);
    reset = 1'b1;
    #1;
    chk("rl_async_sel", int'(program_selector), 0);
    chk("rl_async_busy", int'(busy), 0);
    chk("rl_async_pend", int'(pend_valid), 0);
    chk("rl_no_done", int'(done), 0);
    chk("rl_no_to", int'(timeout), 0);
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("held_no_launch", int'(busy), 0);
    end
    sort_act = 1'b0;
    save_act = 1'b0;
    tick(1);
    push(K_LAUNCH, 2, 4);
    sort_act = 1'b1;
    tick(1);
    chk("repress_sel", int'(program_selector), 2);
    sort_act = 1'b0;
    tick(10);
    finish_run();

    tick(8);
    chk("sb_drained", exp_q.size(), 0);
    chk("sb_no_open_launch", run_len, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
